// File: rtl/servo_pkg.sv
// Shared tick constants and decoder state encoding for the servo tester.
// The generator uses the same constants, so both ends agree on timing.
package servo_pkg;

  localparam int PULSE_MIN     = 10000;
  localparam int STEP_TICKS    = 40;
  localparam int GLITCH_TICKS  = 5000;
  localparam int PULSE_MAX     = 25000;
  localparam int FRAME_TIMEOUT = 250000;

  localparam int CTR_W = 21;

  typedef logic [CTR_W-1:0] ctr_t;

  typedef enum logic [1:0] {
    ARM,
    IDLE,
    HIGH
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic ctr_t sat_inc_ctr(input ctr_t v);
    return (v == '1) ? v : v + ctr_t'(1);
  endfunction

endpackage

// File: rtl/servo_input_sync.sv
// Two-flop synchronizer for the servo pin plus one delay stage
// for rising/falling edge detection.
module servo_input_sync (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic s_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      s    <= 1'b0;
      s_d  <= 1'b0;
    end else begin
      meta <= pwm_in;
      s    <= meta;
      s_d  <= s;
    end
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures RC-servo pulse high time and decodes it to an 8-bit position,
// flagging out-of-range pulses and a missing pulse train.
module servo_pulse_decoder #(
  parameter int PULSE_MIN     = servo_pkg::PULSE_MIN,
  parameter int STEP_TICKS    = servo_pkg::STEP_TICKS,
  parameter int GLITCH_TICKS  = servo_pkg::GLITCH_TICKS,
  parameter int PULSE_MAX     = servo_pkg::PULSE_MAX,
  parameter int FRAME_TIMEOUT = servo_pkg::FRAME_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwm_in,
  output logic [7:0] position,
  output logic       valid,
  output logic       error,
  output logic       lost
);

  import servo_pkg::*;

  localparam ctr_t PMIN_C = ctr_t'(PULSE_MIN);
  localparam ctr_t STEP_C = ctr_t'(STEP_TICKS);
  localparam ctr_t GL_C   = ctr_t'(GLITCH_TICKS);
  localparam ctr_t PMAX_C = ctr_t'(PULSE_MAX);
  localparam ctr_t FT_C   = ctr_t'(FRAME_TIMEOUT);

  logic s;
  logic rise;
  logic fall;

  state_t state;
  state_t state_nxt;

  ctr_t width_ctr;
  ctr_t width_nxt;
  ctr_t step_ctr;
  ctr_t step_nxt;
  ctr_t frame_ctr;
  ctr_t frame_nxt;

  logic [7:0] acc;
  logic [7:0] acc_nxt;
  logic [7:0] position_nxt;
  logic       valid_nxt;
  logic       error_nxt;
  logic       lost_nxt;

  servo_input_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (pwm_in),
    .s      (s),
    .rise   (rise),
    .fall   (fall)
  );

  always_comb begin
    state_nxt    = state;
    width_nxt    = width_ctr;
    step_nxt     = step_ctr;
    acc_nxt      = acc;
    position_nxt = position;
    valid_nxt    = 1'b0;
    error_nxt    = 1'b0;
    lost_nxt     = lost;

    if (rise) begin
      frame_nxt = '0;
    end else if (frame_ctr == FT_C) begin
      frame_nxt = frame_ctr;
    end else begin
      frame_nxt = frame_ctr + ctr_t'(1);
    end

    if (frame_nxt == FT_C && frame_ctr != FT_C) begin
      lost_nxt = 1'b1;
    end

    if (rise) begin
      step_nxt = '0;
      acc_nxt  = '0;
    end

    unique case (state)
      ARM: begin
        if (!s) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (rise) begin
          state_nxt = HIGH;
          width_nxt = ctr_t'(1);
        end
      end
      HIGH: begin
        if (fall) begin
          state_nxt = IDLE;
          if (width_ctr < GL_C) begin
            error_nxt = 1'b1;
          end else begin
            position_nxt = acc;
            valid_nxt    = 1'b1;
            lost_nxt     = 1'b0;
          end
        end else if (width_ctr == PMAX_C) begin
          // stuck-high line: drop it and wait for a low level
          state_nxt = ARM;
          error_nxt = 1'b1;
        end else begin
          width_nxt = sat_inc_ctr(width_ctr);
          if (width_ctr >= PMIN_C) begin
            if (step_ctr == STEP_C - ctr_t'(1)) begin
              step_nxt = '0;
              acc_nxt  = sat_inc8(acc);
            end else begin
              step_nxt = step_ctr + ctr_t'(1);
            end
          end
        end
      end
      default: begin
        state_nxt = ARM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARM;
      width_ctr <= '0;
      step_ctr  <= '0;
      frame_ctr <= '0;
      acc       <= '0;
      position  <= '0;
      valid     <= 1'b0;
      error     <= 1'b0;
      lost      <= 1'b1;
    end else begin
      state     <= state_nxt;
      width_ctr <= width_nxt;
      step_ctr  <= step_nxt;
      frame_ctr <= frame_nxt;
      acc       <= acc_nxt;
      position  <= position_nxt;
      valid     <= valid_nxt;
      error     <= error_nxt;
      lost      <= lost_nxt;
    end
  end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Bench for servo_pulse_decoder with time constants scaled down by 20
// so the whole sequence stays short; decode results scale identically.
module tb_servo_pulse_decoder;

  localparam int P_MIN  = 500;
  localparam int STEP   = 2;
  localparam int GL     = 250;
  localparam int PMAX   = 1250;
  localparam int FT     = 12500;
  localparam int PERIOD = 2500;

  logic       clk = 1'b0;
  logic       reset;
  logic       pwm_in;
  logic [7:0] position;
  logic       valid;
  logic       error;
  logic       lost;

  servo_pulse_decoder #(
    .PULSE_MIN     (P_MIN),
    .STEP_TICKS    (STEP),
    .GLITCH_TICKS  (GL),
    .PULSE_MAX     (PMAX),
    .FRAME_TIMEOUT (FT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pwm_in   (pwm_in),
    .position (position),
    .valid    (valid),
    .error    (error),
    .lost     (lost)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int mis = 0;
  int cyc = 0;

  // behavioural model: pin run lengths -> events, applied two edges later
  bit m_prev;
  bit m_meas;
  int m_run;
  int ref_cyc;
  int ev_kind;
  int ev_pos;
  bit ev_rise;
  int e_kind [2];
  int e_pos  [2];
  bit e_rise [2];
  int x_pos   = 0;
  bit x_valid = 0;
  bit x_error = 0;
  bit x_lost  = 1;

  function automatic int decode(input int n);
    if (n < P_MIN) return 0;
    if ((n - P_MIN) / STEP > 255) return 255;
    return (n - P_MIN) / STEP;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      x_pos   = 0;
      x_valid = 0;
      x_error = 0;
      x_lost  = 1;
      ref_cyc = cyc;
      m_prev  = 0;
      m_meas  = 0;
      m_run   = 0;
      for (int i = 0; i < 2; i++) begin
        e_kind[i] = 0;
        e_pos[i]  = 0;
        e_rise[i] = 0;
      end
    end else begin
      ev_kind = 0;
      ev_pos  = 0;
      ev_rise = pwm_in && !m_prev;
      if (ev_rise) begin
        m_run  = 1;
        m_meas = 1;
      end else if (pwm_in && m_meas) begin
        m_run++;
        if (m_run == PMAX + 1) begin
          ev_kind = 2;
          m_meas  = 0;
        end
      end else if (!pwm_in && m_prev && m_meas) begin
        m_meas = 0;
        if (m_run < GL) begin
          ev_kind = 2;
        end else begin
          ev_kind = 1;
          ev_pos  = decode(m_run);
        end
      end
      x_valid = (e_kind[1] == 1);
      x_error = (e_kind[1] == 2);
      if (e_rise[1]) ref_cyc = cyc;
      if (cyc - ref_cyc == FT) x_lost = 1;
      if (x_valid) begin
        x_pos  = e_pos[1];
        x_lost = 0;
      end
      e_kind[1] = e_kind[0];
      e_pos[1]  = e_pos[0];
      e_rise[1] = e_rise[0];
      e_kind[0] = ev_kind;
      e_pos[0]  = ev_pos;
      e_rise[0] = ev_rise;
      m_prev    = pwm_in;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      vec++;
      if (valid !== x_valid || error !== x_error ||
          lost !== x_lost || position !== 8'(x_pos)) begin
        mis++;
        $display("FAIL cycle %0d outputs: got v=%b e=%b l=%b pos=%0d, want v=%b e=%b l=%b pos=%0d",
                 cyc, valid, error, lost, position,
                 x_valid, x_error, x_lost, x_pos);
      end
    end
  end

  // strobe monitor for the hand-computed checks
  int nvalid = 0;
  int nerror = 0;
  int val_cyc = 0;
  int err_cyc = 0;
  int strobe_pos = 0;
  int lost_set_cyc = 0;
  bit lost_q = 1;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      nvalid++;
      val_cyc    = cyc;
      strobe_pos = int'(position);
    end
    if (error === 1'b1) begin
      nerror++;
      err_cyc = cyc;
    end
    if (lost === 1'b1 && !lost_q) lost_set_cyc = cyc;
    lost_q = (lost === 1'b1);
  end

  task automatic chk(input string name, input int got, input int want);
    vec++;
    if (got !== want) begin
      mis++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n, input int kind, input int epos,
                       input int elat);
    int nv;
    int ne;
    int dc;
    nv = nvalid;
    ne = nerror;
    pwm_in = 1'b1;
    tick(n);
    pwm_in = 1'b0;
    dc = cyc;
    tick(PERIOD - n);
    if (kind == 1) begin
      chk($sformatf("N=%0d valid count", n), nvalid - nv, 1);
      chk($sformatf("N=%0d error count", n), nerror - ne, 0);
      chk($sformatf("N=%0d valid latency", n), val_cyc - dc, elat);
      chk($sformatf("N=%0d position", n), strobe_pos, epos);
    end else begin
      chk($sformatf("N=%0d error count", n), nerror - ne, 1);
      chk($sformatf("N=%0d valid count", n), nvalid - nv, 0);
      chk($sformatf("N=%0d error latency", n), err_cyc - dc, elat);
    end
  endtask

  int nv0;
  int ne0;
  int c0;

  initial begin
    reset  = 1'b1;
    pwm_in = 1'b0;
    tick(4);
    reset = 1'b0;
    chk("reset lost", int'(lost), 1);
    chk("reset position", int'(position), 0);
    chk("reset valid", int'(valid), 0);
    chk("reset error", int'(error), 0);

    nv0 = nvalid;
    ne0 = nerror;
    tick(FT + 100);
    chk("idle lost", int'(lost), 1);
    chk("idle position", int'(position), 0);
    chk("idle strobes", (nvalid - nv0) + (nerror - ne0), 0);

    pulse(500, 1, 0, 3);
    chk("lost cleared", int'(lost), 0);
    pulse(750, 1, 125, 3);
    pulse(1000, 1, 250, 3);
    pulse(1012, 1, 255, 3);
    pulse(1100, 1, 255, 3);

    pulse(750, 1, 125, 3);
    pulse(150, 2, 0, 3);
    chk("glitch keeps position", int'(position), 125);

    nv0 = nvalid;
    ne0 = nerror;
    pwm_in = 1'b1;
    c0 = cyc;
    tick(1500);
    pwm_in = 1'b0;
    tick(FT + 200);
    chk("stuck error count", nerror - ne0, 1);
    chk("stuck error time", err_cyc - c0, PMAX + 3);
    chk("stuck valid count", nvalid - nv0, 0);
    chk("stuck lost time", lost_set_cyc - c0, FT + 3);
    chk("stuck lost level", int'(lost), 1);
    chk("stuck keeps position", int'(position), 125);
    pulse(750, 1, 125, 3);
    chk("lost cleared again", int'(lost), 0);

    nv0 = nvalid;
    ne0 = nerror;
    pwm_in = 1'b1;
    tick(600);
    reset  = 1'b1;
    pwm_in = 1'b0;
    tick(3);
    reset = 1'b0;
    chk("midreset position", int'(position), 0);
    chk("midreset lost", int'(lost), 1);
    tick(20);
    chk("midreset strobes", (nvalid - nv0) + (nerror - ne0), 0);
    pulse(1000, 1, 250, 3);

    pulse(1250, 1, 255, 3);
    pulse(1251, 2, 0, 2);
    pulse(250, 1, 0, 3);
    pulse(249, 2, 0, 3);

    tick(10);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
